id_ex_alu_stage: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline.
- Holds the ID/EX pipeline register, with stall and flush, which latches the decode-stage operands and control signals, including the 4-bit alucontrol produced by the ALU decoder.
- Applies hazard-unit forwarding, evaluates the ALU, and produces the branch target and PC-select for fetch.
- Feeds the EX/MEM register.

---
 rtl/id_ex_alu_stage.sv | 178 +++++++++++++++++
 tb/tb_id_ex_alu_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_stage.sv
// RV32I execute stage: ID/EX pipeline register with stall/flush, forwarding muxes, ALU and branch resolve.
// Optional flush counter output bubble_cnt is enabled by defining EX_BUBBLE_CNT_EN.
module id_ex_alu_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic [3:0]      alucontrol_d,
  input  logic            alusrc_d,
  input  logic            regwrite_d,
  input  logic            memwrite_d,
  input  logic            branch_d,
  input  logic            jump_d,
  input  logic [1:0]      resultsrc_d,
  input  logic [1:0]      forward_ae,
  input  logic [1:0]      forward_be,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] alu_result_e,
  output logic [XLEN-1:0] write_data_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            zero_e,
  output logic            pcsrc_e,
  output logic            regwrite_e,
  output logic            memwrite_e,
  output logic [1:0]      resultsrc_e,
  output logic [4:0]      rd_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e
`ifdef EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]     bubble_cnt
`endif
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  logic [XLEN-1:0]    r_rd1_e;
  logic [XLEN-1:0]    r_rd2_e;
  logic [XLEN-1:0]    r_imm_ext_e;
  logic [XLEN-1:0]    r_pc_e;
  logic [4:0]         r_rs1_e;
  logic [4:0]         r_rs2_e;
  logic [4:0]         r_rd_e;
  logic [3:0]         r_alucontrol_e;
  logic               r_alusrc_e;
  logic               r_regwrite_e;
  logic               r_memwrite_e;
  logic               r_branch_e;
  logic               r_jump_e;
  logic [1:0]         r_resultsrc_e;

  logic [XLEN-1:0]    w_srca;
  logic [XLEN-1:0]    w_write_data;
  logic [XLEN-1:0]    w_srcb;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_alu_result;
  logic               w_zero;

  // ID/EX register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      r_rd1_e        <= '0;
      r_rd2_e        <= '0;
      r_imm_ext_e    <= '0;
      r_pc_e         <= '0;
      r_rs1_e        <= '0;
      r_rs2_e        <= '0;
      r_rd_e         <= '0;
      r_alucontrol_e <= ALU_ADD;
      r_alusrc_e     <= 1'b0;
      r_regwrite_e   <= 1'b0;
      r_memwrite_e   <= 1'b0;
      r_branch_e     <= 1'b0;
      r_jump_e       <= 1'b0;
      r_resultsrc_e  <= '0;
    end else if (!stall_e) begin
      r_rd1_e        <= rd1_d;
      r_rd2_e        <= rd2_d;
      r_imm_ext_e    <= imm_ext_d;
      r_pc_e         <= pc_d;
      r_rs1_e        <= rs1_d;
      r_rs2_e        <= rs2_d;
      r_rd_e         <= rd_d;
      r_alucontrol_e <= alucontrol_d;
      r_alusrc_e     <= alusrc_d;
      r_regwrite_e   <= regwrite_d;
      r_memwrite_e   <= memwrite_d;
      r_branch_e     <= branch_d;
      r_jump_e       <= jump_d;
      r_resultsrc_e  <= resultsrc_d;
    end
  end

  // Forwarding muxes use same-cycle MEM/WB values; code 11 falls back to the register value
  always_comb begin
    w_srca = r_rd1_e;
    case (forward_ae)
      2'b01:   w_srca = result_w;
      2'b10:   w_srca = alu_result_m;
      default: w_srca = r_rd1_e;
    endcase
    w_write_data = r_rd2_e;
    case (forward_be)
      2'b01:   w_write_data = result_w;
      2'b10:   w_write_data = alu_result_m;
      default: w_write_data = r_rd2_e;
    endcase
  end

  assign w_srcb  = r_alusrc_e ? r_imm_ext_e : w_write_data;
  assign w_shamt = w_srcb[SHAMT_W-1:0];

  always_comb begin
    w_alu_result = '0;
    case (r_alucontrol_e)
      ALU_ADD:  w_alu_result = w_srca + w_srcb;
      ALU_SUB:  w_alu_result = w_srca - w_srcb;
      ALU_AND:  w_alu_result = w_srca & w_srcb;
      ALU_OR:   w_alu_result = w_srca | w_srcb;
      ALU_XOR:  w_alu_result = w_srca ^ w_srcb;
      ALU_SLL:  w_alu_result = w_srca << w_shamt;
      ALU_SRL:  w_alu_result = w_srca >> w_shamt;
      ALU_SRA:  w_alu_result = XLEN'($signed(w_srca) >>> w_shamt);
      ALU_SLT:  w_alu_result = XLEN'($signed(w_srca) < $signed(w_srcb));
      ALU_SLTU: w_alu_result = XLEN'(w_srca < w_srcb);
      default:  w_alu_result = '0;
    endcase
  end

  assign w_zero       = (w_alu_result == '0);
  assign alu_result_e = w_alu_result;
  assign zero_e       = w_zero;
  assign write_data_e = w_write_data;
  assign pc_target_e  = r_pc_e + r_imm_ext_e;
  assign pcsrc_e      = r_jump_e | (r_branch_e & w_zero);
  assign regwrite_e   = r_regwrite_e;
  assign memwrite_e   = r_memwrite_e;
  assign resultsrc_e  = r_resultsrc_e;
  assign rd_e         = r_rd_e;
  assign rs1_e        = r_rs1_e;
  assign rs2_e        = r_rs2_e;

`ifdef EX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Saturating count of flushed cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (flush_e && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Directed bench for id_ex_alu_stage: reset, ALU ops, forwarding, branch resolve, stall/flush priority.
module tb_id_ex_alu_stage;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [3:0]  alucontrol_d;
  logic        alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d;
  logic [1:0]  resultsrc_d, forward_ae, forward_be;
  logic [31:0] alu_result_m, result_w;
  logic [31:0] alu_result_e, write_data_e, pc_target_e;
  logic        zero_e, pcsrc_e, regwrite_e, memwrite_e;
  logic [1:0]  resultsrc_e;
  logic [4:0]  rd_e, rs1_e, rs2_e;
`ifdef EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_alu_stage dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
    .alusrc_d(alusrc_d), .regwrite_d(regwrite_d), .memwrite_d(memwrite_d),
    .branch_d(branch_d), .jump_d(jump_d), .resultsrc_d(resultsrc_d),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .alu_result_m(alu_result_m), .result_w(result_w),
    .alu_result_e(alu_result_e), .write_data_e(write_data_e), .pc_target_e(pc_target_e),
    .zero_e(zero_e), .pcsrc_e(pcsrc_e), .regwrite_e(regwrite_e), .memwrite_e(memwrite_e),
    .resultsrc_e(resultsrc_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e)
`ifdef EX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_e = 0; flush_e = 0;
    rd1_d = 0; rd2_d = 0; imm_ext_d = 0; pc_d = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0; alucontrol_d = 0;
    alusrc_d = 0; regwrite_d = 0; memwrite_d = 0; branch_d = 0; jump_d = 0;
    resultsrc_d = 0; forward_ae = 0; forward_be = 0;
    alu_result_m = 0; result_w = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    rd1_d = $urandom; rd2_d = $urandom; imm_ext_d = $urandom; pc_d = $urandom;
    rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
    alucontrol_d = 4'($urandom); alusrc_d = 1; regwrite_d = 1; memwrite_d = 1;
    branch_d = 1; jump_d = 1; resultsrc_d = 2'b11;
    alu_result_m = $urandom; result_w = $urandom;
    step(); step();
    checks++; if (alu_result_e !== 32'd0) begin failures++; $display("FAIL reset_alu_result actual=%h expected=0", alu_result_e); end
    checks++; if (zero_e !== 1'b1) begin failures++; $display("FAIL reset_zero actual=%b expected=1", zero_e); end
    checks++; if (pcsrc_e !== 1'b0) begin failures++; $display("FAIL reset_pcsrc actual=%b expected=0", pcsrc_e); end
    checks++; if (pc_target_e !== 32'd0) begin failures++; $display("FAIL reset_pc_target actual=%h expected=0", pc_target_e); end
    checks++; if (write_data_e !== 32'd0) begin failures++; $display("FAIL reset_write_data actual=%h expected=0", write_data_e); end
    checks++; if (regwrite_e !== 1'b0) begin failures++; $display("FAIL reset_regwrite actual=%b expected=0", regwrite_e); end
    checks++; if (memwrite_e !== 1'b0) begin failures++; $display("FAIL reset_memwrite actual=%b expected=0", memwrite_e); end
    checks++; if (resultsrc_e !== 2'd0) begin failures++; $display("FAIL reset_resultsrc actual=%b expected=0", resultsrc_e); end
    checks++; if ({rd_e, rs1_e, rs2_e} !== 15'd0) begin failures++; $display("FAIL reset_indices actual=%h expected=0", {rd_e, rs1_e, rs2_e}); end
`ifdef EX_BUBBLE_CNT_EN
    checks++; if (bubble_cnt !== 32'd0) begin failures++; $display("FAIL reset_bubble_cnt actual=%0d expected=0", bubble_cnt); end
`endif
    reset = 0;
  endtask

  task automatic test_add_sub();
    clear_inputs();
    rd1_d = 5; rd2_d = 7; alucontrol_d = 4'b0000;
    rs1_d = 5'd3; rs2_d = 5'd4; resultsrc_d = 2'b10;
    step();
    checks++; if (alu_result_e !== 32'd12) begin failures++; $display("FAIL add actual=%h expected=0000000c", alu_result_e); end
    checks++; if ({rs1_e, rs2_e, resultsrc_e} !== {5'd3, 5'd4, 2'b10}) begin failures++; $display("FAIL capture_fields actual=%h expected=%h", {rs1_e, rs2_e, resultsrc_e}, {5'd3, 5'd4, 2'b10}); end
    alucontrol_d = 4'b0001;
    step();
    checks++; if (alu_result_e !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub actual=%h expected=fffffffe", alu_result_e); end
    checks++; if (zero_e !== 1'b0) begin failures++; $display("FAIL sub_zero actual=%b expected=0", zero_e); end
  endtask

  task automatic test_shift_compare();
    clear_inputs();
    alusrc_d = 1; rd1_d = 32'h8000_0000; imm_ext_d = 4; alucontrol_d = 4'b1111;
    step();
    checks++; if (alu_result_e !== 32'hF800_0000) begin failures++; $display("FAIL sra actual=%h expected=f8000000", alu_result_e); end
    alucontrol_d = 4'b0111;
    step();
    checks++; if (alu_result_e !== 32'h0800_0000) begin failures++; $display("FAIL srl actual=%h expected=08000000", alu_result_e); end
    rd1_d = 32'hFFFF_FFFF; imm_ext_d = 1; alucontrol_d = 4'b0101;
    step();
    checks++; if (alu_result_e !== 32'd1) begin failures++; $display("FAIL slt actual=%h expected=1", alu_result_e); end
    alucontrol_d = 4'b1000;
    step();
    checks++; if (alu_result_e !== 32'd0) begin failures++; $display("FAIL sltu actual=%h expected=0", alu_result_e); end
  endtask

  task automatic test_alu_table();
    logic [3:0]  ops [9] = '{4'b0010, 4'b0011, 4'b0110, 4'b0100, 4'b0100, 4'b1000, 4'b0101, 4'b1001, 4'b0001};
    logic [31:0] av  [9] = '{32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd0};
    logic [31:0] bv  [9] = '{32'hFF00, 32'hFF00, 32'hFF00, 32'd31, 32'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd1};
    logic [31:0] ev  [9] = '{32'hF000, 32'hFFF0, 32'h0FF0, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF};
    clear_inputs();
    alusrc_d = 1;
    for (int i = 0; i < 9; i++) begin
      rd1_d = av[i]; imm_ext_d = bv[i]; alucontrol_d = ops[i];
      step();
      checks++;
      if (alu_result_e !== ev[i]) begin
        failures++;
        $display("FAIL alu_table[%0d] op=%b actual=%h expected=%h", i, ops[i], alu_result_e, ev[i]);
      end
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    rd1_d = 1; rd2_d = 0; alucontrol_d = 4'b0000;
    step();
    alu_result_m = 100; result_w = 200;
    forward_ae = 2'b10; #1;
    checks++; if (alu_result_e !== 32'd100) begin failures++; $display("FAIL fwd_a_mem actual=%0d expected=100", alu_result_e); end
    forward_ae = 2'b01; #1;
    checks++; if (alu_result_e !== 32'd200) begin failures++; $display("FAIL fwd_a_wb actual=%0d expected=200", alu_result_e); end
    forward_ae = 2'b11; #1;
    checks++; if (alu_result_e !== 32'd1) begin failures++; $display("FAIL fwd_a_11 actual=%0d expected=1", alu_result_e); end
    forward_ae = 2'b00; forward_be = 2'b01; #1;
    checks++; if (write_data_e !== 32'd200) begin failures++; $display("FAIL fwd_b_wb actual=%0d expected=200", write_data_e); end
    checks++; if (alu_result_e !== 32'd201) begin failures++; $display("FAIL fwd_b_alu actual=%0d expected=201", alu_result_e); end
    forward_be = 2'b10; #1;
    checks++; if (write_data_e !== 32'd100) begin failures++; $display("FAIL fwd_b_mem actual=%0d expected=100", write_data_e); end
    forward_be = 2'b00;
  endtask

  task automatic test_branch_flush();
    clear_inputs();
    branch_d = 1; rd1_d = 9; rd2_d = 9; alucontrol_d = 4'b0001;
    pc_d = 32'h100; imm_ext_d = 32'h20; regwrite_d = 1; rd_d = 5'd5;
    step();
    checks++; if (zero_e !== 1'b1) begin failures++; $display("FAIL branch_zero actual=%b expected=1", zero_e); end
    checks++; if (pcsrc_e !== 1'b1) begin failures++; $display("FAIL branch_pcsrc actual=%b expected=1", pcsrc_e); end
    checks++; if (pc_target_e !== 32'h120) begin failures++; $display("FAIL branch_target actual=%h expected=00000120", pc_target_e); end
    flush_e = 1;
    step();
    flush_e = 0;
    checks++; if (pcsrc_e !== 1'b0) begin failures++; $display("FAIL flush_pcsrc actual=%b expected=0", pcsrc_e); end
    checks++; if (regwrite_e !== 1'b0) begin failures++; $display("FAIL flush_regwrite actual=%b expected=0", regwrite_e); end
    checks++; if (rd_e !== 5'd0) begin failures++; $display("FAIL flush_rd actual=%0d expected=0", rd_e); end
    // jump with nonzero ALU result still redirects
    branch_d = 0; jump_d = 1; rd2_d = 1;
    step();
    checks++; if (pcsrc_e !== 1'b1) begin failures++; $display("FAIL jump_pcsrc actual=%b expected=1", pcsrc_e); end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
    rd_d = 5'd3; regwrite_d = 1; memwrite_d = 1;
    step();
    checks++; if (rd_e !== 5'd3) begin failures++; $display("FAIL load_rd actual=%0d expected=3", rd_e); end
    stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      rd_d = 5'(10 + i); regwrite_d = 0; memwrite_d = 0;
      step();
      checks++;
      if (rd_e !== 5'd3 || regwrite_e !== 1'b1 || memwrite_e !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d] actual rd=%0d rw=%b mw=%b expected rd=3 rw=1 mw=1", i, rd_e, regwrite_e, memwrite_e);
      end
    end
    flush_e = 1;
    step();
    flush_e = 0;
    checks++; if (rd_e !== 5'd0) begin failures++; $display("FAIL stall_flush_rd actual=%0d expected=0", rd_e); end
`ifdef EX_BUBBLE_CNT_EN
    checks++; if (bubble_cnt !== 32'd1) begin failures++; $display("FAIL bubble_cnt actual=%0d expected=1", bubble_cnt); end
`endif
    stall_e = 0; rd_d = 5'd7; regwrite_d = 1;
    step();
    stall_e = 1; reset = 1;
    step();
    reset = 0; stall_e = 0;
    checks++; if (rd_e !== 5'd0 || regwrite_e !== 1'b0) begin failures++; $display("FAIL reset_in_stall actual rd=%0d rw=%b expected rd=0 rw=0", rd_e, regwrite_e); end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_add_sub();
    test_shift_compare();
    test_alu_table();
    test_forwarding();
    test_branch_flush();
    test_stall_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
